// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants, FSM state encoding, requester payload type
// and address range helper for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned AW    = 8;    // address width
  localparam int unsigned DW    = 4;    // data width
  localparam int unsigned DEPTH = 128;  // valid RAM words; addr >= DEPTH is rejected

  // Port indices, also the meaning of the round-robin pointer and grant index.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  // One requester's transaction payload.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // True when the address maps onto a real RAM word.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return addr < AW'(DEPTH);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles both requester handshakes and the RAM pin group.
//   master : requester/RAM environment (drives req/we/addr/wdata, ram_dout)
//   slave  : the arbiter (drives ack/err/rdata, ram_en/rw/addr/din, busy)
interface ram_arbiter_if;
  import ram_arb_pkg::*;

  // Requester A
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          ack_a;
  logic          err_a;
  logic [DW-1:0] rdata_a;
  // Requester B
  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          ack_b;
  logic          err_b;
  logic [DW-1:0] rdata_b;
  // RAM pins
  logic          ram_en;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  // Status
  logic          busy;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_dout,
    input  ack_a, err_a, rdata_a,
    input  ack_b, err_b, rdata_b,
    input  ram_en, ram_rw, ram_addr, ram_din,
    input  busy
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_dout,
    output ack_a, err_a, rdata_a,
    output ack_b, err_b, rdata_b,
    output ram_en, ram_rw, ram_addr, ram_din,
    output busy
  );

endinterface

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational 2-way round-robin picker.
//   req_a, req_b : pending requests
//   ptr          : preferred port (PORT_A / PORT_B)
//   gnt_c        : index of the winning port
//   valid_c      : at least one request is pending
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic gnt_c,
  output logic valid_c
);

  // Preferred port wins a tie; a lone requester always wins.
  always_comb begin
    valid_c = req_a | req_b;
    if (req_a && req_b) begin
      gnt_c = ptr;
    end else if (req_b) begin
      gnt_c = PORT_B;
    end else begin
      gnt_c = PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two req/ack requesters onto a 4-bit x 128-word
// single-port RAM, with round-robin fairness and out-of-range rejection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_arbiter_if.slave -- requester A/B handshakes (req, we,
//                addr, wdata in; ack, err, rdata out), RAM pins (ram_en,
//                ram_rw, ram_addr, ram_din out; ram_dout in), busy out.
// All outputs come straight from flops.
module ram_arbiter
  import ram_arb_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;        // preferred port for the next tie
  logic          gnt_q, gnt_d;        // port owning the current transaction
  logic          ram_en_q, ram_en_d;
  logic          ram_rw_q, ram_rw_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          err_a_q, err_a_d;
  logic          err_b_q, err_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          busy_q, busy_d;

  logic          rr_gnt_c;
  logic          rr_valid_c;
  req_t          pay_a_c;
  req_t          pay_b_c;
  req_t          win_c;

  // Winner selection among the live requests.
  ram_arb_rr u_rr (
    .req_a   (bus.req_a),
    .req_b   (bus.req_b),
    .ptr     (ptr_q),
    .gnt_c   (rr_gnt_c),
    .valid_c (rr_valid_c)
  );

  // Payload of the port the picker would grant this cycle.
  assign pay_a_c = '{we: bus.we_a, addr: bus.addr_a, wdata: bus.wdata_a};
  assign pay_b_c = '{we: bus.we_b, addr: bus.addr_b, wdata: bus.wdata_b};
  assign win_c   = (rr_gnt_c == PORT_B) ? pay_b_c : pay_a_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    ram_en_d   = 1'b0;
    ram_rw_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    err_a_d    = 1'b0;
    err_b_d    = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;

    unique case (state_q)
      IDLE: begin
        if (rr_valid_c) begin
          gnt_d = rr_gnt_c;
          ptr_d = ~rr_gnt_c;
          if (!addr_ok(win_c.addr)) begin
            // Rejected: ack+err land in the next cycle, RAM untouched.
            state_d = ERR;
            ack_a_d = (rr_gnt_c == PORT_A);
            ack_b_d = (rr_gnt_c == PORT_B);
            err_a_d = (rr_gnt_c == PORT_A);
            err_b_d = (rr_gnt_c == PORT_B);
          end else begin
            state_d    = ACCESS;
            ram_en_d   = 1'b1;
            ram_rw_d   = win_c.we;
            ram_addr_d = win_c.addr;
            ram_din_d  = win_c.wdata;
            // A write completes in the ACCESS cycle itself.
            if (win_c.we) begin
              ack_a_d = (rr_gnt_c == PORT_A);
              ack_b_d = (rr_gnt_c == PORT_B);
            end
          end
        end
      end

      ACCESS: begin
        state_d = ram_rw_q ? IDLE : RESP;
      end

      RESP: begin
        // ram_dout holds the addressed word during this cycle.
        state_d = DONE;
        ack_a_d = (gnt_q == PORT_A);
        ack_b_d = (gnt_q == PORT_B);
        if (gnt_q == PORT_A) begin
          rdata_a_d = bus.ram_dout;
        end else begin
          rdata_b_d = bus.ram_dout;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PORT_A;
      gnt_q      <= PORT_A;
      ram_en_q   <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      ram_en_q   <= ram_en_d;
      ram_rw_q   <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.err_a    = err_a_q;
  assign bus.err_b    = err_b_q;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_rw   = ram_rw_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. Contains a behavioural
// RAM, a transaction-level reference model, a directed vector table,
// randomized traffic and hand-written reset / sustained-request sequences.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
  } txn_t;

  typedef struct {
    logic       ra;
    logic       rb;
    txn_t       tx_a;
    txn_t       tx_b;
    int         cyc_a;   // ack cycle counted from the sampling IDLE cycle
    int         cyc_b;
    logic       err_a;
    logic       err_b;
    logic [3:0] rd_a;    // rdata seen in the ack cycle
    logic [3:0] rd_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 4x128 RAM: output register updates at the edge ending a read.
  logic [3:0] ram_mem [128];
  logic [3:0] ram_dout_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= '0;
      ram_dout_r <= '0;
    end else if (bus.ram_en) begin
      if (bus.ram_rw) ram_mem[bus.ram_addr[6:0]] <= bus.ram_din;
      else            ram_dout_r <= ram_mem[bus.ram_addr[6:0]];
    end
  end
  assign bus.ram_dout = ram_dout_r;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [3:0] mem_m [128];
  logic       ptr_m;          // 0 = A preferred, 1 = B preferred
  logic [3:0] rd_m [2];

  vec_t vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = '0;
    ptr_m = 1'b0;
    rd_m[0] = '0;
    rd_m[1] = '0;
  endtask

  function automatic int lat_of(input txn_t t);
    if (t.addr >= 8'd128) return 1;
    return t.we ? 1 : 3;
  endfunction

  function automatic txn_t mk_txn(input logic we, input logic [7:0] addr, input logic [3:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    return t;
  endfunction

  function automatic vec_t mk(input logic ra, input logic rb, input txn_t ta, input txn_t tb_,
                              input int ca, input int cb, input logic ea, input logic eb,
                              input logic [3:0] qa, input logic [3:0] qb);
    vec_t v;
    v.ra = ra; v.rb = rb; v.tx_a = ta; v.tx_b = tb_;
    v.cyc_a = ca; v.cyc_b = cb; v.err_a = ea; v.err_b = eb; v.rd_a = qa; v.rd_b = qb;
    return v;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    int   sel;
    sel     = int'($urandom_range(0, 9));
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = 4'($urandom_range(0, 15));
    if (sel == 0)      t.addr = 8'($urandom_range(128, 255));
    else if (sel == 1) t.addr = 8'($urandom_range(120, 127));
    else               t.addr = 8'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ack_a"},    int'(bus.ack_a), 0);
    chk({tag, "_ack_b"},    int'(bus.ack_b), 0);
    chk({tag, "_err_a"},    int'(bus.err_a), 0);
    chk({tag, "_err_b"},    int'(bus.err_b), 0);
    chk({tag, "_busy"},     int'(bus.busy), 0);
    chk({tag, "_ram_en"},   int'(bus.ram_en), 0);
    chk({tag, "_ram_rw"},   int'(bus.ram_rw), 0);
    chk({tag, "_ram_addr"}, int'(bus.ram_addr), 0);
    chk({tag, "_ram_din"},  int'(bus.ram_din), 0);
    chk({tag, "_rdata_a"},  int'(bus.rdata_a), 0);
    chk({tag, "_rdata_b"},  int'(bus.rdata_b), 0);
  endtask

  // Runs one or two simultaneous transactions, checks them against the
  // reference model and returns what was observed at each ack.
  task automatic exec(input vec_t v, input string tag, output vec_t o);
    txn_t       t [2];
    logic       r [2];
    logic       pend [2];
    int         e_cyc [2];
    logic       e_err [2];
    logic [3:0] e_rd [2];
    txn_t       en_q [$];
    int         first, p, base, cyc, en_cnt;

    t[0] = v.tx_a; t[1] = v.tx_b; r[0] = v.ra; r[1] = v.rb;
    o = v;
    o.cyc_a = 0; o.cyc_b = 0; o.err_a = 1'b0; o.err_b = 1'b0; o.rd_a = '0; o.rd_b = '0;
    e_cyc[0] = 0; e_cyc[1] = 0; e_err[0] = 1'b0; e_err[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;

    // Model: grant order, completion cycles, RAM effect, pointer update.
    if (r[0] && r[1]) first = int'(ptr_m);
    else              first = r[1] ? 1 : 0;
    base = 0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (r[p]) begin
        e_cyc[p] = base + lat_of(t[p]);
        base     = e_cyc[p] + 1;
        e_err[p] = (t[p].addr >= 8'd128);
        if (!e_err[p]) begin
          en_q.push_back(t[p]);
          if (t[p].we) mem_m[t[p].addr[6:0]] = t[p].wdata;
          else         rd_m[p] = mem_m[t[p].addr[6:0]];
        end
        e_rd[p] = rd_m[p];
        ptr_m   = (p == 0);
      end
    end

    @(negedge clk);
    bus.req_a = r[0]; bus.we_a = t[0].we; bus.addr_a = t[0].addr; bus.wdata_a = t[0].wdata;
    bus.req_b = r[1]; bus.we_b = t[1].we; bus.addr_b = t[1].addr; bus.wdata_b = t[1].wdata;
    pend[0] = r[0]; pend[1] = r[1];
    cyc = 0; en_cnt = 0;
    while ((pend[0] || pend[1]) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk({tag, "_dual_ack"}, int'(bus.ack_a & bus.ack_b), 0);
      chk({tag, "_spurious_ack_a"}, int'(bus.ack_a & ~pend[0]), 0);
      chk({tag, "_spurious_ack_b"}, int'(bus.ack_b & ~pend[1]), 0);
      if (bus.ram_en) begin
        if (en_cnt < en_q.size()) begin
          chk({tag, "_ram_rw"},   int'(bus.ram_rw),   int'(en_q[en_cnt].we));
          chk({tag, "_ram_addr"}, int'(bus.ram_addr), int'(en_q[en_cnt].addr));
          chk({tag, "_ram_din"},  int'(bus.ram_din),  int'(en_q[en_cnt].wdata));
        end
        en_cnt++;
      end
      if (bus.ack_a && pend[0]) begin
        o.cyc_a = cyc; o.err_a = bus.err_a; o.rd_a = bus.rdata_a;
        chk({tag, "_busy_ack_a"}, int'(bus.busy), 1);
        pend[0] = 1'b0; bus.req_a = 1'b0;
      end
      if (bus.ack_b && pend[1]) begin
        o.cyc_b = cyc; o.err_b = bus.err_b; o.rd_b = bus.rdata_b;
        chk({tag, "_busy_ack_b"}, int'(bus.busy), 1);
        pend[1] = 1'b0; bus.req_b = 1'b0;
      end
    end
    chk({tag, "_timeout"}, int'(pend[0] | pend[1]), 0);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    chk({tag, "_ram_en_count"}, en_cnt, en_q.size());
    if (r[0]) begin
      chk({tag, "_model_cyc_a"}, o.cyc_a, e_cyc[0]);
      chk({tag, "_model_err_a"}, int'(o.err_a), int'(e_err[0]));
      chk({tag, "_model_rd_a"},  int'(o.rd_a), int'(e_rd[0]));
    end
    if (r[1]) begin
      chk({tag, "_model_cyc_b"}, o.cyc_b, e_cyc[1]);
      chk({tag, "_model_err_b"}, int'(o.err_b), int'(e_err[1]));
      chk({tag, "_model_rd_b"},  int'(o.rd_b), int'(e_rd[1]));
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    chk({tag, "_idle_en"},   int'(bus.ram_en), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t       o;
    vec_t       rv;
    txn_t       nil;
    int         k, na, b_cyc, cyc;
    int         a_cyc [$];
    logic [3:0] a_rd [$];
    int         exp_ac [4];
    logic [3:0] exp_ard [4];

    nil = mk_txn(1'b0, 8'd0, 4'd0);
    //            ra rb  tx_a                        tx_b                        ca cb ea eb rd_a   rd_b
    vecs[0]  = mk(1, 1, mk_txn(1, 8'd1,   4'h3),   mk_txn(1, 8'd2,   4'h6),   1, 3, 0, 0, 4'h0, 4'h0);
    vecs[1]  = mk(1, 0, mk_txn(0, 8'd1,   4'h0),   nil,                       3, 0, 0, 0, 4'h3, 4'h0);
    vecs[2]  = mk(1, 0, mk_txn(0, 8'd2,   4'h0),   nil,                       3, 0, 0, 0, 4'h6, 4'h0);
    vecs[3]  = mk(1, 1, mk_txn(1, 8'd3,   4'h7),   mk_txn(1, 8'd4,   4'h8),   3, 1, 0, 0, 4'h6, 4'h0);
    vecs[4]  = mk(1, 0, mk_txn(1, 8'd5,   4'hA),   nil,                       1, 0, 0, 0, 4'h6, 4'h0);
    vecs[5]  = mk(1, 0, mk_txn(0, 8'd5,   4'h0),   nil,                       3, 0, 0, 0, 4'hA, 4'h0);
    vecs[6]  = mk(0, 1, nil,                       mk_txn(0, 8'h80,  4'h0),   0, 1, 0, 1, 4'h0, 4'h0);
    vecs[7]  = mk(1, 0, mk_txn(1, 8'd127, 4'hF),   nil,                       1, 0, 0, 0, 4'hA, 4'h0);
    vecs[8]  = mk(1, 0, mk_txn(0, 8'd127, 4'h0),   nil,                       3, 0, 0, 0, 4'hF, 4'h0);
    vecs[9]  = mk(0, 1, nil,                       mk_txn(0, 8'd4,   4'h0),   0, 3, 0, 0, 4'h0, 4'h8);
    vecs[10] = mk(1, 1, mk_txn(0, 8'hFF,  4'h0),   mk_txn(0, 8'd3,   4'h0),   1, 5, 1, 0, 4'hF, 4'h7);
    vecs[11] = mk(0, 1, nil,                       mk_txn(1, 8'h90,  4'h5),   0, 1, 0, 1, 4'h0, 4'h7);
    vecs[12] = mk(1, 1, mk_txn(0, 8'd1,   4'h0),   mk_txn(0, 8'd2,   4'h0),   3, 7, 0, 0, 4'h3, 4'h6);

    rst_n = 1'b0;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      exec(vecs[i], $sformatf("vec%0d", i), o);
      if (vecs[i].ra) begin
        chk($sformatf("vec%0d_cyc_a", i), o.cyc_a, vecs[i].cyc_a);
        chk($sformatf("vec%0d_err_a", i), int'(o.err_a), int'(vecs[i].err_a));
        chk($sformatf("vec%0d_rd_a", i),  int'(o.rd_a), int'(vecs[i].rd_a));
      end
      if (vecs[i].rb) begin
        chk($sformatf("vec%0d_cyc_b", i), o.cyc_b, vecs[i].cyc_b);
        chk($sformatf("vec%0d_err_b", i), int'(o.err_b), int'(vecs[i].err_b));
        chk($sformatf("vec%0d_rd_b", i),  int'(o.rd_b), int'(vecs[i].rd_b));
      end
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(1, 3));
      rv = mk(k[0], k[1], rnd_txn(), rnd_txn(), 0, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      exec(rv, $sformatf("rnd%0d", i), o);
    end

    // Reset asserted while a read sits in RESP: no ack, async clear.
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 8'd1;
    @(negedge clk);
    chk("rstseq_access_en", int'(bus.ram_en), 1);
    @(negedge clk);
    chk("rstseq_resp_busy", int'(bus.busy), 1);
    chk("rstseq_resp_ack",  int'(bus.ack_a), 0);
    #1 rst_n = 1'b0;
    bus.req_a = 1'b0;
    #1 check_reset_outs("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_ack", int'(bus.ack_a), 0);
    end
    rst_n = 1'b1;
    model_reset();
    rv = mk(0, 1, nil, mk_txn(0, 8'd1, 4'h0), 0, 0, 1'b0, 1'b0, 4'h0, 4'h0);
    exec(rv, "postrst", o);
    chk("postrst_rd_b", int'(o.rd_b), 0);

    // A streams 4 reads holding req; B's single write must slot in after A's first.
    exp_ac  = '{3, 9, 13, 17};
    exp_ard = '{4'h0, 4'h9, 4'h0, 4'h0};
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 8'd10;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 8'd11; bus.wdata_b = 4'h9;
    na = 0; b_cyc = 0; cyc = 0;
    while ((na < 4 || b_cyc == 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk("sus_dual_ack", int'(bus.ack_a & bus.ack_b), 0);
      if (bus.ack_b && b_cyc == 0) begin
        b_cyc = cyc;
        bus.req_b = 1'b0;
      end
      if (bus.ack_a && na < 4) begin
        a_cyc.push_back(cyc);
        a_rd.push_back(bus.rdata_a);
        na++;
        if (na < 4) bus.addr_a = 8'(10 + na);
        else        bus.req_a = 1'b0;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    chk("sus_b_cyc", b_cyc, 5);
    chk("sus_a_count", na, 4);
    for (int i = 0; i < na; i++) begin
      chk($sformatf("sus_a%0d_cyc", i), a_cyc[i], exp_ac[i]);
      chk($sformatf("sus_a%0d_rd", i), int'(a_rd[i]), int'(exp_ard[i]));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the 4-bit × 128-entry single-port RAM. Two independent requesters (port A, port B) issue read or write transactions with a req/ack handshake. The block serialises them onto the RAM's EN/RW/address/data pins, captures registered read data, and rejects out-of-range addresses. It sits directly in front of the RAM instance and is the only master driving it.

## Interface
- AW, 8: address width presented by requesters and driven to the RAM.
- DW, 4: data width.
- DEPTH, 128: number of valid RAM words; addresses ≥ DEPTH are out of range.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a / req_b  in  1  transaction request; held high, payload stable, until ack.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  AW  word address.
- wdata_a / wdata_b  in  DW  write data.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- err_a / err_b  out  1  pulses with ack when the address was out of range.
- rdata_a / rdata_b  out  DW  read data; valid in the ack cycle of a read; holds until the next read on that port.
- ram_en  out  1  to RAM EN.
- ram_rw  out  1  to RAM RW (1 = write).
- ram_addr  out  AW  to RAM address.
- ram_din  out  DW  to RAM data_in.
- ram_dout  in  DW  from RAM data_out; the RAM updates it at the clock edge ending a read-enabled cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, RESP, DONE, ERR.
- IDLE → winner selection when any req is high.
  - Out-of-range address (addr ≥ DEPTH, i.e. addr[7] = 1): go to ERR.
  - Otherwise go to ACCESS, registering ram_en = 1, ram_rw = we, ram_addr, ram_din from the winner.
- ACCESS: ram_en high for exactly this cycle.
  - Write: ack_x pulses in this cycle; next state is IDLE.
  - Read: next state is RESP.
- RESP: ram_dout now holds the word. Load rdata_x from ram_dout at the end of this cycle. Next state is DONE.
- DONE: ack_x pulses. Next state is IDLE.
- ERR: ack_x and err_x pulse together. No RAM access and rdata_x unchanged. Next state is IDLE.
- Round-robin: a 1-bit pointer names the preferred port (reset: A).
  - If both ports request, the preferred port wins; if only one requests, it wins.
  - After every grant, including ERR, the pointer moves to the non-winning port.
- Outside ACCESS: ram_en = 0, ram_rw = 0. ram_addr and ram_din hold their last value.
- Requester rule: deassert req, or present a new transaction, on the edge after ack. A req still high in IDLE is treated as a new transaction.
- ack and err are never asserted to both ports in the same cycle.

## Timing
- Latencies, with cycle 0 = IDLE cycle in which req is sampled:
  - Write: ram_en and ack in cycle 1; IDLE again in cycle 2.
  - Read: ram_en in cycle 1, RESP in cycle 2, ack and rdata in cycle 3; IDLE in cycle 4.
  - Error: ack and err in cycle 1.
- Throughput: one write per 2 cycles; one read per 4 cycles.
- Reset values: state IDLE, pointer A, all ack/err/busy/ram_en/ram_rw = 0, ram_addr = 0, ram_din = 0, rdata_a = rdata_b = 0.
- Reset mid-transaction: abandon immediately, with no ack. A write in ACCESS may or may not have landed. The RAM shares rst_n and clears on its own.
- A req arriving while busy waits; it is not lost and not reordered against the other port beyond round-robin.

## Structure
- Shared package ram_arb_pkg holds:
  - the state encoding (IDLE, ACCESS, RESP, DONE, ERR);
  - the constants DEPTH = 128, AW = 8, DW = 4;
  - the port-index constants PORT_A = 0, PORT_B = 1.
- Sub-module ram_arb_rr is the 2-way round-robin picker. Inputs: req_a, req_b, pointer. Outputs: grant index, valid. It is combinational; the pointer register stays in the top.
- The top holds the FSM, grant-index register, RAM output registers and per-port rdata registers.

## Test plan
- Write then read on one port: A writes 4'hA to address 5 → ack_a in cycle 1. A then reads address 5 → ack_a with rdata_a = 4'hA exactly 3 cycles after sample, and ram_en high for one cycle each time.
- Simultaneous contention: A and B both write (A: addr 1 ← 3; B: addr 2 ← 6) from reset → A granted first, then B. Readback gives 3 and 6. A further simultaneous pair is granted B first.
- Out-of-range: B reads addr 8'h80 → ack_b and err_b in cycle 1, ram_en never asserted, rdata_b unchanged, pointer moves to A.
- Sustained request: A holds req with 4 back-to-back reads while B requests once → B is served after A's first transaction, never starved.
- Boundary address: write 4'hF to address 127, then read it back → 4'hF, err_a = 0.
- Reset mid-read: assert rst_n low during RESP → all outputs go to their reset values asynchronously and no ack is issued. After release, a fresh read of any address returns 0.
